// File: rtl/mc_main_fsm.sv
// Multi-cycle RV32I main control FSM: sequences the shared memory port, ALU and IR/PC/data registers.
// Latency: lw 5, sw/R/I/jal 4, beq 3 cycles; memory states stall on mem_ready and abort after MEM_TIMEOUT waits.
// Backpressure: mem_ready low holds FETCH/MEMREAD/MEMWRITE. `define ILLEGAL_OP_TRAP_EN adds the TRAP lock state and the illegal_op port.
module mc_main_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ImmSrc,
   output logic       RegWrite,
   output logic [1:0] ALUOp,
   output logic       mem_err
`ifdef ILLEGAL_OP_TRAP_EN
   ,
   output logic       illegal_op
`endif
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam bit               TO_EN   = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             waiting, timeout, branch, pc_update;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      AdrSrc    = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      ResultSrc = 2'b00;
      ALUSrcA   = 2'b00;
      ALUSrcB   = 2'b00;
      RegWrite  = 1'b0;
      ALUOp     = 2'b00;
      mem_err   = 1'b0;
      branch    = 1'b0;
      pc_update = 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
      illegal_op = 1'b0;
`endif

      waiting = !mem_ready &&
                (state_q == FETCH || state_q == MEMREAD || state_q == MEMWRITE);
      timeout = TO_EN && waiting && (cnt_q == TO_LAST);

      case (state_q)
         FETCH: begin
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_ready;
            pc_update = mem_ready;
            if (mem_ready) state_d = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECR;
               OP_I:         state_d = EXECI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
`ifdef ILLEGAL_OP_TRAP_EN
               default:      state_d = TRAP;
`else
               default:      state_d = FETCH;
`endif
            endcase
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_d = FETCH;
         end
         EXECR: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ALUOp   = 2'b10;
            state_d = ALUWB;
         end
         ALUWB: begin
            RegWrite = 1'b1;
            state_d  = FETCH;
         end
         BEQ: begin
            ALUSrcA = 2'b10;
            ALUOp   = 2'b01;
            branch  = 1'b1;
            state_d = FETCH;
         end
         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
            state_d   = ALUWB;
         end
         TRAP: begin
`ifdef ILLEGAL_OP_TRAP_EN
            illegal_op = 1'b1;
            state_d    = TRAP;
`else
            state_d    = FETCH;
`endif
         end
         default: state_d = FETCH;
      endcase

      // Abort a stalled access; the partial store must not be committed.
      if (timeout) begin
         state_d  = FETCH;
         MemWrite = 1'b0;
         mem_err  = 1'b1;
      end

      PCWrite = (branch & zero) | pc_update;

      case (op)
         OP_LW, OP_I: ImmSrc = 2'b00;
         OP_SW:       ImmSrc = 2'b01;
         OP_BEQ:      ImmSrc = 2'b10;
         OP_JAL:      ImmSrc = 2'b11;
         default:     ImmSrc = 2'b00;
      endcase

      // A timed-out FETCH stays in FETCH, so the count restarts explicitly.
      if (timeout || state_d != state_q) cnt_d = '0;
      else if (waiting)                  cnt_d = cnt_q + 1'b1;
      else                               cnt_d = cnt_q;
   end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm: the stimulus side queues per-cycle expected control words, a monitor compares them.
module tb_mc_main_fsm;
   localparam int TO = 4;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BQ  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;

   logic       clk, rst, zero, mem_ready;
   logic [6:0] op;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, mem_err;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp;

   typedef struct packed {
      logic       pcw;
      logic       adr;
      logic       memw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] srca;
      logic [1:0] srcb;
      logic [1:0] imm;
      logic       regw;
      logic [1:0] aluop;
      logic       err;
   } ov_t;

   ov_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   mc_main_fsm #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .ALUOp(ALUOp), .mem_err(mem_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic ov_t mk(input logic adr, input logic memw, input logic [1:0] res,
                              input logic [1:0] srca, input logic [1:0] srcb,
                              input logic regw, input logic [1:0] aluop);
      ov_t v;
      v = '0;
      v.adr = adr; v.memw = memw; v.res = res; v.srca = srca;
      v.srcb = srcb; v.regw = regw; v.aluop = aluop;
      return v;
   endfunction

   function automatic logic [1:0] imm_of(input logic [6:0] o);
      if (o == LW || o == IT) return 2'b00;
      if (o == SW) return 2'b01;
      if (o == BQ) return 2'b10;
      if (o == JL) return 2'b11;
      return 2'b00;
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
   endfunction

   function automatic logic rz();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic int rw();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(TO, TO + 2));
      return int'($urandom_range(0, 3));
   endfunction

   function automatic string fmt(input ov_t v);
      return $sformatf("pcw=%b adr=%b memw=%b irw=%b res=%b srcA=%b srcB=%b imm=%b regw=%b aluop=%b err=%b",
                       v.pcw, v.adr, v.memw, v.irw, v.res, v.srca, v.srcb, v.imm, v.regw, v.aluop, v.err);
   endfunction

   // Control word of each phase of an instruction, straight from the control table.
   function automatic ov_t fetch_ov();    return mk(0, 0, 2'b10, 2'b00, 2'b10, 0, 2'b00); endfunction
   function automatic ov_t decode_ov();   return mk(0, 0, 2'b00, 2'b01, 2'b01, 0, 2'b00); endfunction
   function automatic ov_t memadr_ov();   return mk(0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b00); endfunction
   function automatic ov_t memread_ov();  return mk(1, 0, 2'b00, 2'b00, 2'b00, 0, 2'b00); endfunction
   function automatic ov_t memwb_ov();    return mk(0, 0, 2'b01, 2'b00, 2'b00, 1, 2'b00); endfunction
   function automatic ov_t memwrite_ov(); return mk(1, 1, 2'b00, 2'b00, 2'b00, 0, 2'b00); endfunction
   function automatic ov_t execr_ov();    return mk(0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b10); endfunction
   function automatic ov_t execi_ov();    return mk(0, 0, 2'b00, 2'b10, 2'b01, 0, 2'b10); endfunction
   function automatic ov_t aluwb_ov();    return mk(0, 0, 2'b00, 2'b00, 2'b00, 1, 2'b00); endfunction
   function automatic ov_t beq_ov();      return mk(0, 0, 2'b00, 2'b10, 2'b00, 0, 2'b01); endfunction
   function automatic ov_t jal_ov();
      ov_t v;
      v = mk(0, 0, 2'b00, 2'b01, 2'b10, 0, 2'b00);
      v.pcw = 1'b1;
      return v;
   endfunction

   // Monitor: one expected control word per cycle, compared mid-cycle.
   initial begin
      ov_t e, act;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            act.pcw = PCWrite;     act.adr = AdrSrc;    act.memw = MemWrite;
            act.irw = IRWrite;     act.res = ResultSrc; act.srca = ALUSrcA;
            act.srcb = ALUSrcB;    act.imm = ImmSrc;    act.regw = RegWrite;
            act.aluop = ALUOp;     act.err = mem_err;
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL ctrl_word t=%0t op=%b mr=%b actual {%s} required {%s}",
                        $time, op, mem_ready, fmt(act), fmt(e));
            end
         end
      end
   end

   task automatic step(input logic mr, input ov_t e, input bit br, input logic z);
      mem_ready = mr;
      zero      = z;
      e.imm     = imm_of(op);
      if (br) e.pcw = z;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // A memory-waiting phase: `waits` cycles with mem_ready low, then completion,
   // unless the wait budget runs out first (error pulse, access abandoned).
   task automatic mem_phase(input ov_t base, input int waits, input bit is_fetch, output bit ok);
      ov_t e;
      ok = 1'b0;
      for (int i = 0; i < waits; i++) begin
         if (is_fetch) op = 7'($urandom);
         e = base;
         if (i == TO - 1) begin
            e.err  = 1'b1;
            e.memw = 1'b0;
            step(1'b0, e, 1'b0, rz());
            return;
         end
         step(1'b0, e, 1'b0, rz());
      end
      if (is_fetch) op = 7'($urandom);
      e = base;
      if (is_fetch) begin
         e.irw = 1'b1;
         e.pcw = 1'b1;
      end
      step(1'b1, e, 1'b0, rz());
      ok = 1'b1;
   endtask

   task automatic fetch(input int waits);
      bit ok;
      mem_phase(fetch_ov(), waits, 1'b1, ok);
      while (!ok) mem_phase(fetch_ov(), rw(), 1'b1, ok);
   endtask

   // kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal, 6 unsupported op. zsel 2 = random zero.
   task automatic run_instr(input int kind, input int fw, input int mw, input int zsel);
      logic [6:0] opc;
      bit         ok;
      logic       z;
      case (kind)
         0: opc = LW;
         1: opc = SW;
         2: opc = RT;
         3: opc = IT;
         4: opc = BQ;
         5: opc = JL;
         default: begin
            opc = 7'($urandom);
            while (is_legal(opc)) opc = 7'($urandom);
         end
      endcase
      fetch(fw);
      op = opc;
      step(rz(), decode_ov(), 1'b0, rz());
      case (kind)
         0: begin
            step(rz(), memadr_ov(), 1'b0, rz());
            mem_phase(memread_ov(), mw, 1'b0, ok);
            if (ok) step(rz(), memwb_ov(), 1'b0, rz());
         end
         1: begin
            step(rz(), memadr_ov(), 1'b0, rz());
            mem_phase(memwrite_ov(), mw, 1'b0, ok);
         end
         2: begin
            step(rz(), execr_ov(), 1'b0, rz());
            step(rz(), aluwb_ov(), 1'b0, rz());
         end
         3: begin
            step(rz(), execi_ov(), 1'b0, rz());
            step(rz(), aluwb_ov(), 1'b0, rz());
         end
         4: begin
            z = (zsel == 2) ? rz() : 1'(zsel);
            step(rz(), beq_ov(), 1'b1, z);
         end
         5: begin
            step(rz(), jal_ov(), 1'b0, rz());
            step(rz(), aluwb_ov(), 1'b0, rz());
         end
         default: ;
      endcase
   endtask

   initial begin
      ov_t  e;
      logic mr;
      rst = 1'b0; op = '0; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk);
      #1;
      // In reset the outputs follow the fetch decode, gated by mem_ready.
      repeat (3) begin
         mr = rz();
         op = 7'($urandom);
         e = fetch_ov();
         e.irw = mr;
         e.pcw = mr;
         step(mr, e, 1'b0, rz());
      end
      rst = 1'b1;

      run_instr(0, 0, 0, 2);
      run_instr(4, 0, 0, 1);
      run_instr(4, 0, 0, 0);
      run_instr(5, 0, 0, 2);
      run_instr(1, 1, 3, 2);
      run_instr(0, 0, TO + 2, 2);
      run_instr(1, 0, TO, 2);
      run_instr(0, 3, 3, 2);
      run_instr(2, 0, 0, 2);
      run_instr(3, TO + 1, 0, 2);
      run_instr(6, 0, 0, 2);

      // Asynchronous reset in the middle of a stalled store.
      fetch(0);
      op = SW;
      step(rz(), decode_ov(), 1'b0, rz());
      step(rz(), memadr_ov(), 1'b0, rz());
      step(1'b0, memwrite_ov(), 1'b0, rz());
      step(1'b0, memwrite_ov(), 1'b0, rz());
      mem_ready = 1'b0;
      e = fetch_ov();
      e.imm = imm_of(op);
      exp_q.push_back(e);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      e = fetch_ov();
      e.irw = 1'b1;
      e.pcw = 1'b1;
      step(1'b1, e, 1'b0, rz());
      rst = 1'b1;
      run_instr(0, 2, 1, 2);

      repeat (300) run_instr(int'($urandom_range(0, 6)), rw(), rw(), 2);

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected words left, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
